// File: rtl/pio_bank_pkg.sv
// Shared definitions for the mezzanine-A PIO bank controller: register
// addresses, the per-lane turnaround state encoding and a counter sizing helper.
package pio_bank_pkg;

  localparam logic [2:0] ADDR_OUT        = 3'd0;
  localparam logic [2:0] ADDR_DIR        = 3'd1;
  localparam logic [2:0] ADDR_IN         = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN    = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN    = 3'd4;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MASK   = 3'd6;
  localparam logic [2:0] ADDR_LANE_BUSY  = 3'd7;

  typedef enum logic [1:0] {
    LANE_IDLE   = 2'd0,
    LANE_OFF    = 2'd1,
    LANE_SETTLE = 2'd2
  } lane_state_e;

  // Width of a counter that must hold the value turn_cycles.
  function automatic int turn_cnt_width(input int turn_cycles);
    return (turn_cycles < 1) ? 1 : $clog2(turn_cycles + 1);
  endfunction

endpackage

// File: rtl/pio_lane_turnaround.sv
// One byte lane's transceiver turnaround sequencer. The transceiver is disabled
// for TURN_CYCLES clocks before and after the applied direction changes, so the
// board-side driver and the transceiver never fight over the pins.
module pio_lane_turnaround
  import pio_bank_pkg::*;
#(
  parameter int TURN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic dir,
  output logic oe_b,
  output logic busy,
  output logic valid
);

  localparam int CW = turn_cnt_width(TURN_CYCLES);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  lane_state_e   state_q;
  logic [CW-1:0] cnt_q;

  // Break-before-make sequence; the request is only sampled when leaving OFF,
  // so rewrites during the sequence just update what gets applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LANE_IDLE;
      cnt_q   <= '0;
      dir     <= 1'b0;
      oe_b    <= 1'b0;
    end else begin
      case (state_q)
        LANE_IDLE: begin
          if (req != dir) begin
            state_q <= LANE_OFF;
            cnt_q   <= TURN_LOAD;
            oe_b    <= 1'b1;
          end
        end
        LANE_OFF: begin
          if (cnt_q == CNT_ONE) begin
            dir     <= req;
            state_q <= LANE_SETTLE;
            cnt_q   <= TURN_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        LANE_SETTLE: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= LANE_IDLE;
            cnt_q   <= '0;
            oe_b    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= LANE_IDLE;
          cnt_q   <= '0;
          oe_b    <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = (state_q != LANE_IDLE);
  assign valid = (state_q == LANE_IDLE) && !dir;

endmodule

// File: rtl/pio_bank_ctrl.sv
// Mezzanine-A PIO bank controller: register file, per-lane turnaround
// sequencers, input synchronisers, edge detection and the maskable IRQ.
module pio_bank_ctrl
  import pio_bank_pkg::*;
#(
  parameter int LANES       = 6,
  parameter int TURN_CYCLES = 4,
  parameter int SYNC_STAGES = 2,
  localparam int W          = 8 * LANES
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  input  logic [2:0]       REG_ADDR,
  input  logic             REG_WR,
  input  logic             REG_RD,
  input  logic [W-1:0]     REG_WDATA,
  output logic [W-1:0]     REG_RDATA,
  input  logic [W-1:0]     PIO_IN,
  output logic [W-1:0]     PIO_OUT,
  output logic [LANES-1:0] PIO_DIR,
  output logic [LANES-1:0] PIO_OE_B,
  output logic             PIO_IRQ
);

  logic [W-1:0]     out_q;
  logic [W-1:0]     rise_en_q;
  logic [W-1:0]     fall_en_q;
  logic [W-1:0]     irq_status_q;
  logic [W-1:0]     irq_mask_q;
  logic [W-1:0]     prev_q;
  logic [W-1:0]     sync_q [SYNC_STAGES];
  logic [W-1:0]     sync_in;
  logic [W-1:0]     valid_bits;
  logic [W-1:0]     edge_set;
  logic [W-1:0]     status_clr;
  logic [W-1:0]     rd_mux;
  logic [LANES-1:0] dir_req_q;
  logic [LANES-1:0] lane_busy;
  logic [LANES-1:0] lane_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pio_lane_turnaround #(
      .TURN_CYCLES(TURN_CYCLES)
    ) u_lane (
      .clk  (SYS_CLK),
      .rst  (SYS_RST),
      .req  (dir_req_q[i]),
      .dir  (PIO_DIR[i]),
      .oe_b (PIO_OE_B[i]),
      .busy (lane_busy[i]),
      .valid(lane_valid[i])
    );
    assign valid_bits[8*i +: 8] = {8{lane_valid[i]}};
  end

  // Plain read/write registers; IRQ_STATUS is handled with the edge logic.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      out_q      <= '0;
      dir_req_q  <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_mask_q <= '0;
    end else if (REG_WR) begin
      case (REG_ADDR)
        ADDR_OUT:      out_q      <= REG_WDATA;
        ADDR_DIR:      dir_req_q  <= REG_WDATA[LANES-1:0];
        ADDR_RISE_EN:  rise_en_q  <= REG_WDATA;
        ADDR_FALL_EN:  fall_en_q  <= REG_WDATA;
        ADDR_IRQ_MASK: irq_mask_q <= REG_WDATA;
        default: ;
      endcase
    end
  end

  assign PIO_OUT = out_q;

  // Multi-flop synchroniser on every raw pin.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= PIO_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Previous synchronised value, tracked even while a lane is turning around.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) prev_q <= '0;
    else         prev_q <= sync_in;
  end

  assign edge_set   = ((sync_in & ~prev_q & rise_en_q) | (~sync_in & prev_q & fall_en_q)) & valid_bits;
  assign status_clr = (REG_WR && (REG_ADDR == ADDR_IRQ_STATUS)) ? REG_WDATA : '0;

  // Sticky status with write-one-to-clear (a new edge beats a clear) and the registered IRQ.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      irq_status_q <= '0;
      PIO_IRQ      <= 1'b0;
    end else begin
      irq_status_q <= (irq_status_q & ~status_clr) | edge_set;
      PIO_IRQ      <= |(irq_status_q & irq_mask_q);
    end
  end

  // Read data selection; narrow registers are zero-extended.
  always_comb begin
    rd_mux = '0;
    case (REG_ADDR)
      ADDR_OUT:        rd_mux = out_q;
      ADDR_DIR:        rd_mux[LANES-1:0] = dir_req_q;
      ADDR_IN:         rd_mux = sync_in;
      ADDR_RISE_EN:    rd_mux = rise_en_q;
      ADDR_FALL_EN:    rd_mux = fall_en_q;
      ADDR_IRQ_STATUS: rd_mux = irq_status_q;
      ADDR_IRQ_MASK:   rd_mux = irq_mask_q;
      ADDR_LANE_BUSY:  rd_mux[LANES-1:0] = lane_busy;
      default:         rd_mux = '0;
    endcase
  end

  // Registered read data, held between read strobes.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST)     REG_RDATA <= '0;
    else if (REG_RD) REG_RDATA <= rd_mux;
  end

endmodule

// File: tb/tb_pio_bank_ctrl.sv
// Bench for pio_bank_ctrl: directed turnaround/IRQ scenarios plus random
// register and pin traffic, all compared every cycle against a timestamp-based
// behavioural model of the bank.
module tb_pio_bank_ctrl;

  localparam int LANES = 6;
  localparam int T     = 4;
  localparam int SS    = 2;
  localparam int W     = 8 * LANES;

  logic             SYS_CLK;
  logic             SYS_RST;
  logic [2:0]       REG_ADDR;
  logic             REG_WR;
  logic             REG_RD;
  logic [W-1:0]     REG_WDATA;
  logic [W-1:0]     REG_RDATA;
  logic [W-1:0]     PIO_IN;
  logic [W-1:0]     PIO_OUT;
  logic [LANES-1:0] PIO_DIR;
  logic [LANES-1:0] PIO_OE_B;
  logic             PIO_IRQ;

  pio_bank_ctrl #(
    .LANES(LANES),
    .TURN_CYCLES(T),
    .SYNC_STAGES(SS)
  ) dut (
    .SYS_CLK  (SYS_CLK),
    .SYS_RST  (SYS_RST),
    .REG_ADDR (REG_ADDR),
    .REG_WR   (REG_WR),
    .REG_RD   (REG_RD),
    .REG_WDATA(REG_WDATA),
    .REG_RDATA(REG_RDATA),
    .PIO_IN   (PIO_IN),
    .PIO_OUT  (PIO_OUT),
    .PIO_DIR  (PIO_DIR),
    .PIO_OE_B (PIO_OE_B),
    .PIO_IRQ  (PIO_IRQ)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lanes are described by when their sequence started and ended.
  int               cyc;
  logic [W-1:0]     m_out, m_rise, m_fall, m_stat, m_mask, m_rdata;
  logic [LANES-1:0] m_req, m_applied;
  logic             m_irq;
  int               m_start [LANES];
  int               m_end   [LANES];
  logic [W-1:0]     m_hist [$];
  logic [W-1:0]     pin_drive;

  task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic bit laneBusyAt(input int i, input int c);
    return (c >= m_start[i]) && (c < m_end[i]);
  endfunction

  task automatic modelReset();
    m_out = '0; m_rise = '0; m_fall = '0; m_stat = '0; m_mask = '0; m_rdata = '0;
    m_req = '0; m_applied = '0; m_irq = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      m_start[i] = -100;
      m_end[i]   = -100;
    end
    m_hist = {};
    for (int s = 0; s <= SS; s++) m_hist.push_back('0);
  endtask

  task automatic modelEdge(input bit wr, input bit rd, input logic [2:0] addr,
                           input logic [W-1:0] wdata, input logic [W-1:0] pin);
    logic [W-1:0]     sync_old, prev_old, valid, set, clr, stat_old;
    logic [LANES-1:0] applied_old, req_old, busy_old;
    cyc++;
    sync_old    = m_hist[SS-1];
    prev_old    = m_hist[SS];
    applied_old = m_applied;
    req_old     = m_req;
    stat_old    = m_stat;
    valid       = '0;
    for (int i = 0; i < LANES; i++) begin
      busy_old[i] = laneBusyAt(i, cyc - 1);
      if (!busy_old[i] && !applied_old[i]) valid[8*i +: 8] = 8'hFF;
    end
    for (int i = 0; i < LANES; i++) begin
      if (busy_old[i]) begin
        if (cyc == m_start[i] + T) m_applied[i] = req_old[i];
      end else if (req_old[i] != applied_old[i]) begin
        m_start[i] = cyc;
        m_end[i]   = cyc + 2 * T;
      end
    end
    if (rd) begin
      m_rdata = '0;
      case (addr)
        3'd0: m_rdata = m_out;
        3'd1: m_rdata[LANES-1:0] = req_old;
        3'd2: m_rdata = sync_old;
        3'd3: m_rdata = m_rise;
        3'd4: m_rdata = m_fall;
        3'd5: m_rdata = stat_old;
        3'd6: m_rdata = m_mask;
        default: m_rdata[LANES-1:0] = busy_old;
      endcase
    end
    set    = ((sync_old & ~prev_old & m_rise) | (~sync_old & prev_old & m_fall)) & valid;
    clr    = (wr && addr == 3'd5) ? wdata : '0;
    m_irq  = |(stat_old & m_mask);
    m_stat = (stat_old & ~clr) | set;
    if (wr) begin
      case (addr)
        3'd0: m_out  = wdata;
        3'd1: m_req  = wdata[LANES-1:0];
        3'd3: m_rise = wdata;
        3'd4: m_fall = wdata;
        3'd6: m_mask = wdata;
        default: ;
      endcase
    end
    m_hist.push_front(pin);
    void'(m_hist.pop_back());
  endtask

  task automatic compareAll();
    logic [LANES-1:0] exp_oe;
    for (int i = 0; i < LANES; i++) exp_oe[i] = laneBusyAt(i, cyc);
    checkOutput("pio_out", PIO_OUT, m_out);
    checkOutput("pio_dir", W'(PIO_DIR), W'(m_applied));
    checkOutput("pio_oe_b", W'(PIO_OE_B), W'(exp_oe));
    checkOutput("pio_irq", W'(PIO_IRQ), W'(m_irq));
    checkOutput("reg_rdata", REG_RDATA, m_rdata);
  endtask

  task automatic applyStimulus(input bit wr, input bit rd, input logic [2:0] addr, input logic [W-1:0] wdata);
    REG_WR    = wr;
    REG_RD    = rd;
    REG_ADDR  = addr;
    REG_WDATA = wdata;
    PIO_IN    = pin_drive;
    @(posedge SYS_CLK);
    modelEdge(wr, rd, addr, wdata, pin_drive);
    #1;
    compareAll();
    REG_WR = 1'b0;
    REG_RD = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 3'd0, '0);
  endtask

  task automatic regWrite(input logic [2:0] addr, input logic [W-1:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
  endtask

  task automatic regRead(input logic [2:0] addr);
    applyStimulus(1'b0, 1'b1, addr, '0);
  endtask

  task automatic asyncResetCheck();
    regWrite(3'd0, 48'hA5A5_1234_5678);
    regWrite(3'd1, 48'h3F);
    regRead(3'd0);
    idle();
    #2 SYS_RST = 1'b1;
    #1;
    checkOutput("rst_pio_out", PIO_OUT, '0);
    checkOutput("rst_pio_dir", W'(PIO_DIR), '0);
    checkOutput("rst_pio_oe_b", W'(PIO_OE_B), '0);
    checkOutput("rst_pio_irq", W'(PIO_IRQ), '0);
    checkOutput("rst_reg_rdata", REG_RDATA, '0);
    modelReset();
    @(posedge SYS_CLK);
    #1 SYS_RST = 1'b0;
    regRead(3'd7);
    checkOutput("rst_lane_busy", REG_RDATA, '0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0]  rnd;
    logic [W-1:0] one_bit;
    bit           wr, rd;
    logic [2:0]   addr;
    int           r;

    SYS_RST = 1'b1; REG_WR = 1'b0; REG_RD = 1'b0; REG_ADDR = '0; REG_WDATA = '0;
    pin_drive = '0; PIO_IN = '0; cyc = 0;
    modelReset();
    repeat (2) @(posedge SYS_CLK);
    #1;
    checkOutput("reset_pio_out", PIO_OUT, '0);
    checkOutput("reset_pio_dir", W'(PIO_DIR), '0);
    checkOutput("reset_pio_oe_b", W'(PIO_OE_B), '0);
    checkOutput("reset_pio_irq", W'(PIO_IRQ), '0);
    checkOutput("reset_reg_rdata", REG_RDATA, '0);
    SYS_RST = 1'b0;

    $display("[TB] Lane 0 turnaround to output");
    regWrite(3'd1, 48'h01);
    for (int k = 1; k <= 9; k++) begin
      idle();
      if (k == 1) checkOutput("t2_oe_off", W'(PIO_OE_B), 48'h01);
      if (k == 4) checkOutput("t2_dir_hold", W'(PIO_DIR), 48'h00);
      if (k == 5) checkOutput("t2_dir_flip", W'(PIO_DIR), 48'h01);
      if (k == 8) checkOutput("t2_oe_still_off", W'(PIO_OE_B), 48'h01);
      if (k == 9) checkOutput("t2_oe_on", W'(PIO_OE_B), 48'h00);
    end
    regWrite(3'd1, 48'h00);
    repeat (10) idle();

    $display("[TB] Lane 0 request withdrawn mid-sequence");
    regWrite(3'd1, 48'h01);
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) regWrite(3'd1, 48'h00);
      else        idle();
      if (k == 5)  checkOutput("t3_no_flip", W'(PIO_DIR), 48'h00);
      if (k == 8)  checkOutput("t3_oe_off", W'(PIO_OE_B), 48'h01);
      if (k == 9)  checkOutput("t3_oe_on", W'(PIO_OE_B), 48'h00);
      if (k == 10) checkOutput("t3_no_restart", W'(PIO_OE_B), 48'h00);
    end

    $display("[TB] Rising edge interrupt on bit 0");
    regWrite(3'd3, {W{1'b1}});
    regWrite(3'd4, {W{1'b1}});
    regWrite(3'd6, 48'h01);
    pin_drive[0] = 1'b1;
    idle();
    regRead(3'd2);
    checkOutput("t4_in_early", REG_RDATA & 48'h1, 48'h0);
    regRead(3'd2);
    checkOutput("t4_in_sync", REG_RDATA & 48'h1, 48'h1);
    regRead(3'd5);
    checkOutput("t4_status", REG_RDATA & 48'h1, 48'h1);
    checkOutput("t4_irq_on", W'(PIO_IRQ), 48'h1);
    regWrite(3'd5, 48'h01);
    idle();
    checkOutput("t4_irq_off", W'(PIO_IRQ), 48'h0);

    $display("[TB] Bit 8 toggles during lane 1 turnaround");
    regWrite(3'd1, 48'h02);
    for (int k = 1; k <= 8; k++) begin
      if (k <= 6) pin_drive[8] = ~pin_drive[8];
      idle();
    end
    repeat (3) idle();
    regRead(3'd5);
    checkOutput("t5_status8", REG_RDATA & 48'h100, 48'h0);
    regWrite(3'd1, 48'h00);
    repeat (10) idle();

    $display("[TB] Clear colliding with a new edge");
    pin_drive[0] = 1'b0;
    repeat (4) idle();
    regWrite(3'd5, {W{1'b1}});
    idle();
    pin_drive[0] = 1'b1;
    idle();
    idle();
    regWrite(3'd5, 48'h01);
    regRead(3'd5);
    checkOutput("t6_set_wins", REG_RDATA & 48'h1, 48'h1);

    $display("[TB] Random traffic");
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        one_bit   = 1;
        pin_drive = pin_drive ^ (one_bit << $urandom_range(0, W - 1));
      end
      r    = $urandom_range(0, 15);
      addr = 3'($urandom_range(0, 7));
      rnd  = {$urandom, $urandom};
      wr   = (r < 3);
      rd   = (r >= 2 && r < 6);
      if (wr && addr == 3'd1 && $urandom_range(0, 3) != 0) wr = 1'b0;
      applyStimulus(wr, rd, addr, rnd[W-1:0]);
      if (n == 700) asyncResetCheck();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
